parity_frame_rx: RTL and testbench
==================================

Name: parity_frame_rx

Overview:
Serial frame receiver/sequencer wrapped around a 9-bit parity datapath (8 data bits + 1 parity bit).
- Walks each incoming frame through start, data, parity and stop phases.
- Accumulates the running XOR of the data bits and checks it against the received parity bit (even or odd).
- Presents each completed byte, with error flags, through a one-entry valid/ready output buffer.
- Sits between a bit-rate sampler (which supplies one strobe per bit) and downstream byte consumers.

Parameters:
DATA_W, 8, number of data bits per frame; legal range 2..16.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
sin_valid  input  1  bit strobe; sin is sampled only in cycles where this is 1.
sin  input  1  serial line bit; idle level 1.
odd_sel  input  1  parity mode, latched at the start bit: 0 = even, 1 = odd.
clr_ovr  input  1  synchronous clear of the overrun flag.
out_ready  input  1  consumer accepts data_out in this cycle.
data_out  output  DATA_W  received data, first bit received in bit 0.
data_valid  output  1  data_out and its error flags are held and valid.
parity_err  output  1  parity mismatch for the frame in data_out.
frame_err  output  1  stop bit was 0 for the frame in data_out.
overrun  output  1  sticky: a completed frame was dropped because the buffer was full.
busy  output  1  1 while the FSM is not in IDLE.

Behaviour:
- Reset: the async assert of rst_n forces state IDLE. It also clears data_out=0, data_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0, and all internal counters, shift and parity registers. Release is synchronous to clk.
- Bit consumption: the FSM advances only in cycles where sin_valid=1. When sin_valid=0, all state holds. There is no timeout.
- IDLE:
  - sin_valid & sin=0 -> DATA. Latch odd_sel into odd_l; clear cnt=0, par=0.
  - sin_valid & sin=1 -> stay in IDLE.
- DATA: on each strobe, shift sin into the shift register (first bit lands at bit 0 after DATA_W shifts), set par ^= sin, cnt++. The strobe with cnt==DATA_W-1 moves to PAR.
- PAR: on the strobe, compute perr = par ^ sin ^ odd_l, then go to STOP.
  - Even mode: perr=1 when the XOR over data+parity is 1.
  - Odd mode: perr=1 when that XOR is 0.
- STOP: on the strobe, compute ferr = ~sin. The frame is then complete; go to IDLE. The next start bit may arrive on the very next strobe.
- Frame completion, resolved in the same cycle:
  - If data_valid=0, or data_valid=1 & out_ready=1: load data_out, parity_err=perr and frame_err=ferr; data_valid=1 on the next cycle.
  - If data_valid=1 & out_ready=0: discard the new frame, keep the buffer unchanged, set overrun=1.
- Latency: data_valid rises 1 clk after the cycle that samples the stop bit.
- Handshake: a transfer happens when data_valid & out_ready. With no new completion that cycle, data_valid drops on the next edge. Buffer outputs must not change while data_valid=1 & out_ready=0.
- Framing errors: a frame with a bad stop bit is still delivered, with frame_err=1. A break (continuous 0) is not special-cased; it is handled as repeated frames.
- overrun: cleared only by clr_ovr=1 or reset. If clr_ovr coincides with a new overrun event, the set wins.
- Mode change: a change of odd_sel in mid-frame has no effect until the next start bit.
- busy = (state != IDLE).
- Reset mid-frame: the partial frame is lost, and the buffered byte and overrun flag are cleared.

Test Plan:
- Even OK: odd_sel=0; strobe start 0, data 0xA5 sent as 1,0,1,0,0,1,0,1, parity 0, stop 1 -> data_out=0xA5, data_valid=1 one clk after the stop strobe, parity_err=0, frame_err=0.
- Parity error: odd_sel=1, same frame -> data_out=0xA5, parity_err=1. Then odd_sel=1 with parity bit 1 -> parity_err=0.
- Framing error: 0x3C, correct even parity bit 0, stop bit 0 -> data_out=0x3C, frame_err=1, parity_err=0. FSM returns to IDLE and accepts an immediately following 0x01 frame correctly.
- Backpressure/overrun: out_ready=0, send 0x11 then 0x22 -> data_out stays 0x11 and overrun=1. Raise out_ready for 1 clk -> data_valid=0 next cycle. Pulse clr_ovr -> overrun=0.
- Same-cycle consume+load: hold 0x11 with out_ready=0; assert out_ready exactly in the completion cycle of 0x22 -> data_out=0x22, data_valid stays 1, overrun=0.
- Gaps and reset: insert random sin_valid=0 gaps inside a frame, with odd_sel toggling mid-frame -> result identical to the gap-free run. Drop rst_n after 4 data bits -> all outputs 0 immediately, busy=0; the next full frame decodes correctly.

Source files
------------

// File: rtl/parity_frame_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : parity_frame_rx_if
// Description : Bit-strobe input side and buffered byte output side of the
//               parity frame receiver.
//               master : bit sampler / consumer side (drives strobes, ready,
//                        mode and overrun clear; observes buffer outputs)
//               slave  : receiver side
//               Signals: sin_valid, sin, odd_sel, clr_ovr, out_ready (to rx)
//                        data_out, data_valid, parity_err, frame_err,
//                        overrun, busy (from rx)
// Revision    : 1.0 - initial release
// ============================================================================
interface parity_frame_rx_if #(
    parameter int DATA_W = 8
);
    logic              sin_valid;
    logic              sin;
    logic              odd_sel;
    logic              clr_ovr;
    logic              out_ready;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              parity_err;
    logic              frame_err;
    logic              overrun;
    logic              busy;

    modport master (
        output sin_valid, sin, odd_sel, clr_ovr, out_ready,
        input  data_out, data_valid, parity_err, frame_err, overrun, busy
    );

    modport slave (
        input  sin_valid, sin, odd_sel, clr_ovr, out_ready,
        output data_out, data_valid, parity_err, frame_err, overrun, busy
    );
endinterface
`default_nettype wire

// File: rtl/parity_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : parity_frame_rx
// Description : Serial frame receiver. Walks each frame through start, data,
//               parity and stop phases (one phase step per sin_valid strobe),
//               checks even/odd parity and presents each completed word with
//               parity/framing error flags through a one-entry valid/ready
//               buffer. A frame completing while the buffer is full and not
//               being drained is dropped and sets the sticky overrun flag.
// Ports       : clk   - system clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - parity_frame_rx_if.slave (strobe input, byte output)
// Revision    : 1.0 - initial release
// ============================================================================
module parity_frame_rx #(
    parameter int DATA_W = 8
) (
    input  wire                clk,
    input  wire                rst_n,
    parity_frame_rx_if.slave   bus
);

    localparam int c_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_PAR  = 2'd2,
        S_STOP = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0]   r_shift;
    logic                r_par;
    logic                r_odd;
    logic                r_perr;
    logic [DATA_W-1:0]   r_data;
    logic                r_valid;
    logic                r_perr_out;
    logic                r_ferr_out;
    logic                r_ovr;
    logic                w_done;
    logic                w_load;
    logic                w_drop;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and buffer control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        if (bus.sin_valid) begin
            case (r_state)
                S_IDLE: if (!bus.sin) w_state_nxt = S_DATA;
                S_DATA: if (r_cnt == c_CNT_LAST) w_state_nxt = S_PAR;
                S_PAR:  w_state_nxt = S_STOP;
                S_STOP: begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
        // A draining buffer can take the new word in the same cycle.
        w_load = w_done & (~r_valid | bus.out_ready);
        w_drop = w_done & r_valid & ~bus.out_ready;
    end

    // ------------------------------------------------------------------
    // Datapath: shift, running parity, output buffer, overrun
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_odd      <= 1'b0;
            r_perr     <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_perr_out <= 1'b0;
            r_ferr_out <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            if (bus.sin_valid) begin
                case (r_state)
                    S_IDLE: begin
                        // Parity mode is frozen for the whole frame here.
                        if (!bus.sin) begin
                            r_odd <= bus.odd_sel;
                            r_cnt <= '0;
                            r_par <= 1'b0;
                        end
                    end
                    S_DATA: begin
                        // Shift in at the MSB so the first bit ends at bit 0.
                        r_shift <= {bus.sin, r_shift[DATA_W-1:1]};
                        r_par   <= r_par ^ bus.sin;
                        r_cnt   <= r_cnt + c_CNT_W'(1);
                    end
                    S_PAR: begin
                        r_perr <= r_par ^ bus.sin ^ r_odd;
                    end
                    default: ;
                endcase
            end

            if (w_load) begin
                r_data     <= r_shift;
                r_perr_out <= r_perr;
                r_ferr_out <= ~bus.sin;
                r_valid    <= 1'b1;
            end else if (r_valid && bus.out_ready) begin
                r_valid <= 1'b0;
            end

            // A new overrun beats a coincident clear.
            if (w_drop) begin
                r_ovr <= 1'b1;
            end else if (bus.clr_ovr) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign bus.data_out   = r_data;
    assign bus.data_valid = r_valid;
    assign bus.parity_err = r_perr_out;
    assign bus.frame_err  = r_ferr_out;
    assign bus.overrun    = r_ovr;
    assign bus.busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_parity_frame_rx
// Description : Self-checking bench for parity_frame_rx. Frames are driven
//               bit by bit; the expected buffer contents come from a
//               transaction-level model (parity from a ones count, buffer
//               occupancy and overrun from the handshake rules).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_frame_rx;

    localparam int DW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    parity_frame_rx_if #(.DATA_W(DW)) bus ();

    parity_frame_rx #(.DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected buffer state
    logic [DW-1:0] exp_data  = '0;
    logic          exp_valid = 1'b0;
    logic          exp_perr  = 1'b0;
    logic          exp_ferr  = 1'b0;
    logic          exp_ovr   = 1'b0;

    // One clock cycle; done marks the stop-bit strobe of a frame.
    task automatic tick(input logic sv, input logic b, input logic done,
                        input logic [DW-1:0] d, input logic pe, input logic fe);
        logic rdy;
        logic clr;
        @(negedge clk);
        bus.sin_valid = sv;
        bus.sin       = b;
        rdy = bus.out_ready;
        clr = bus.clr_ovr;
        @(posedge clk);
        #1;
        bus.sin_valid = 1'b0;
        bus.sin       = 1'b1;
        if (done && exp_valid && !rdy) begin
            exp_ovr = 1'b1;
        end else begin
            if (done) begin
                exp_data  = d;
                exp_perr  = pe;
                exp_ferr  = fe;
                exp_valid = 1'b1;
            end else if (exp_valid && rdy) begin
                exp_valid = 1'b0;
            end
            if (clr) exp_ovr = 1'b0;
        end
    endtask

    task automatic flush();
        bus.out_ready = 1'b1;
        tick(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        bus.out_ready = 1'b0;
    endtask

    // Full frame: start, data LSB first, parity, stop.
    task automatic send_frame(input logic [DW-1:0] d, input logic mode,
                              input logic pbit, input logic stopb,
                              input bit gaps, input bit rnd_rdy,
                              input bit rdy_stop, input bit clr_stop);
        logic pe;
        logic fe;
        logic b;
        int   ones;
        ones = $countones({d, pbit});
        pe   = mode ? ((ones % 2) == 0) : ((ones % 2) == 1);
        fe   = ~stopb;
        bus.odd_sel = mode;
        for (int i = 0; i < DW + 3; i++) begin
            if (i == 0)           b = 1'b0;
            else if (i <= DW)     b = d[i-1];
            else if (i == DW + 1) b = pbit;
            else                  b = stopb;
            if (gaps) begin
                for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
                    if (i > 0) bus.odd_sel = 1'($urandom);
                    if (rnd_rdy) bus.out_ready = 1'($urandom);
                    tick(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
                end
            end
            if (rnd_rdy) bus.out_ready = 1'($urandom);
            if (i == DW + 2) begin
                if (rdy_stop) bus.out_ready = 1'b1;
                if (clr_stop) bus.clr_ovr = 1'b1;
            end
            tick(1'b1, b, (i == DW + 2), d, pe, fe);
            if (i == DW + 2) begin
                if (rdy_stop) bus.out_ready = 1'b0;
                bus.clr_ovr = 1'b0;
            end
            if (gaps && i > 0) bus.odd_sel = 1'($urandom);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.data_valid, bus.parity_err, bus.frame_err, bus.overrun, bus.busy, bus.data_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got dv=%b pe=%b fe=%b ovr=%b busy=%b data=%h, want all 0",
                     bus.data_valid, bus.parity_err, bus.frame_err, bus.overrun, bus.busy, bus.data_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_even_ok();
        logic [DW-1:0] d;
        d = 8'hA5;
        bus.odd_sel = 1'b0;
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_start: got %b want 1", bus.busy);
        end
        for (int i = 0; i < DW; i++) tick(1'b1, d[i], 1'b0, '0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if (bus.data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_before_stop: got %b want 0", bus.data_valid);
        end
        tick(1'b1, 1'b1, 1'b1, d, 1'b0, 1'b0);
        n_checks++;
        if ({bus.data_valid, bus.parity_err, bus.frame_err, bus.busy, bus.data_out} !== {4'b1000, 8'hA5}) begin
            n_fail++;
            $display("FAIL even_ok: got dv=%b pe=%b fe=%b busy=%b data=%h want 1 0 0 0 a5",
                     bus.data_valid, bus.parity_err, bus.frame_err, bus.busy, bus.data_out);
        end
        flush();
        n_checks++;
        if (bus.data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL consume_even: got dv=%b want 0", bus.data_valid);
        end
    endtask

    task automatic test_parity_err();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0);
        n_checks++;
        if ({bus.data_valid, bus.parity_err, bus.frame_err, bus.data_out} !== {3'b110, 8'hA5}) begin
            n_fail++;
            $display("FAIL odd_bad_parity: got dv=%b pe=%b fe=%b data=%h want 1 1 0 a5",
                     bus.data_valid, bus.parity_err, bus.frame_err, bus.data_out);
        end
        flush();
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 0, 0, 0, 0);
        n_checks++;
        if ({bus.data_valid, bus.parity_err, bus.frame_err, bus.data_out} !== {3'b100, 8'hA5}) begin
            n_fail++;
            $display("FAIL odd_good_parity: got dv=%b pe=%b fe=%b data=%h want 1 0 0 a5",
                     bus.data_valid, bus.parity_err, bus.frame_err, bus.data_out);
        end
        flush();
    endtask

    task automatic test_frame_err();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        n_checks++;
        if ({bus.data_valid, bus.parity_err, bus.frame_err, bus.busy, bus.data_out} !== {4'b1010, 8'h3C}) begin
            n_fail++;
            $display("FAIL frame_err: got dv=%b pe=%b fe=%b busy=%b data=%h want 1 0 1 0 3c",
                     bus.data_valid, bus.parity_err, bus.frame_err, bus.busy, bus.data_out);
        end
        bus.out_ready = 1'b1;
        send_frame(8'h01, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0);
        n_checks++;
        if ({bus.data_valid, bus.parity_err, bus.frame_err, bus.overrun, bus.data_out} !== {4'b1000, 8'h01}) begin
            n_fail++;
            $display("FAIL after_frame_err: got dv=%b pe=%b fe=%b ovr=%b data=%h want 1 0 0 0 01",
                     bus.data_valid, bus.parity_err, bus.frame_err, bus.overrun, bus.data_out);
        end
        tick(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
        n_checks++;
        if ({bus.data_valid, bus.overrun, bus.data_out} !== {2'b11, 8'h11}) begin
            n_fail++;
            $display("FAIL overrun_hold: got dv=%b ovr=%b data=%h want 1 1 11",
                     bus.data_valid, bus.overrun, bus.data_out);
        end
        flush();
        n_checks++;
        if ({bus.data_valid, bus.overrun} !== 2'b01) begin
            n_fail++;
            $display("FAIL drain_after_overrun: got dv=%b ovr=%b want 0 1", bus.data_valid, bus.overrun);
        end
        bus.clr_ovr = 1'b1;
        tick(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        bus.clr_ovr = 1'b0;
        n_checks++;
        if (bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_ovr: got ovr=%b want 0", bus.overrun);
        end
    endtask

    task automatic test_same_cycle();
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 0, 0, 1, 0);
        n_checks++;
        if ({bus.data_valid, bus.overrun, bus.data_out} !== {2'b10, 8'h22}) begin
            n_fail++;
            $display("FAIL consume_and_load: got dv=%b ovr=%b data=%h want 1 0 22",
                     bus.data_valid, bus.overrun, bus.data_out);
        end
        // Overrun coinciding with a clear: the overrun wins.
        send_frame(8'h33, 1'b0, 1'b0, 1'b1, 0, 0, 0, 1);
        n_checks++;
        if ({bus.data_valid, bus.overrun, bus.data_out} !== {2'b11, 8'h22}) begin
            n_fail++;
            $display("FAIL set_beats_clear: got dv=%b ovr=%b data=%h want 1 1 22",
                     bus.data_valid, bus.overrun, bus.data_out);
        end
        flush();
        bus.clr_ovr = 1'b1;
        tick(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        bus.clr_ovr = 1'b0;
    endtask

    task automatic test_gaps();
        logic [DW-1:0] d;
        logic          mode, pbit, stopb;
        logic [DW+1:0] ref_run;
        for (int k = 0; k < 6; k++) begin
            d     = DW'($urandom);
            mode  = 1'($urandom);
            pbit  = 1'($urandom);
            stopb = 1'($urandom);
            send_frame(d, mode, pbit, stopb, 0, 0, 0, 0);
            ref_run = {bus.parity_err, bus.frame_err, bus.data_out};
            n_checks++;
            if ({bus.data_valid, bus.parity_err, bus.frame_err, bus.data_out} !== {exp_valid, exp_perr, exp_ferr, exp_data}) begin
                n_fail++;
                $display("FAIL gapfree_%0d: got dv=%b pe=%b fe=%b data=%h want %b %b %b %h", k,
                         bus.data_valid, bus.parity_err, bus.frame_err, bus.data_out,
                         exp_valid, exp_perr, exp_ferr, exp_data);
            end
            flush();
            send_frame(d, mode, pbit, stopb, 1, 0, 0, 0);
            n_checks++;
            if ({bus.data_valid, bus.parity_err, bus.frame_err, bus.data_out} !== {1'b1, ref_run}
                || ref_run !== {exp_perr, exp_ferr, exp_data}) begin
                n_fail++;
                $display("FAIL gapped_%0d: got dv=%b pe=%b fe=%b data=%h want 1 %b %b %h", k,
                         bus.data_valid, bus.parity_err, bus.frame_err, bus.data_out,
                         exp_perr, exp_ferr, exp_data);
            end
            flush();
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 16; k++) begin
            send_frame(DW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                       1, 1, 0, ($urandom_range(0, 3) == 0));
            n_checks++;
            if ({bus.data_valid, bus.parity_err, bus.frame_err, bus.overrun, bus.data_out}
                !== {exp_valid, exp_perr, exp_ferr, exp_ovr, exp_data}) begin
                n_fail++;
                $display("FAIL random_%0d: got dv=%b pe=%b fe=%b ovr=%b data=%h want %b %b %b %b %h", k,
                         bus.data_valid, bus.parity_err, bus.frame_err, bus.overrun, bus.data_out,
                         exp_valid, exp_perr, exp_ferr, exp_ovr, exp_data);
            end
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d;
        d = 8'hC3;
        // Fill the buffer and set overrun so the reset has something to clear.
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b1, d[i], 1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if ({bus.busy, bus.data_valid, bus.overrun} !== 3'b111) begin
            n_fail++;
            $display("FAIL before_mid_reset: got busy=%b dv=%b ovr=%b want 1 1 1",
                     bus.busy, bus.data_valid, bus.overrun);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.data_valid, bus.parity_err, bus.frame_err, bus.overrun, bus.busy, bus.data_out} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got dv=%b pe=%b fe=%b ovr=%b busy=%b data=%h want all 0",
                     bus.data_valid, bus.parity_err, bus.frame_err, bus.overrun, bus.busy, bus.data_out);
        end
        exp_valid = 1'b0;
        exp_perr  = 1'b0;
        exp_ferr  = 1'b0;
        exp_ovr   = 1'b0;
        exp_data  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
        n_checks++;
        if ({bus.data_valid, bus.parity_err, bus.frame_err, bus.overrun, bus.data_out} !== {4'b1000, 8'h5A}) begin
            n_fail++;
            $display("FAIL after_mid_reset: got dv=%b pe=%b fe=%b ovr=%b data=%h want 1 0 0 0 5a",
                     bus.data_valid, bus.parity_err, bus.frame_err, bus.overrun, bus.data_out);
        end
        flush();
    endtask

    initial begin
        bus.sin_valid = 1'b0;
        bus.sin       = 1'b1;
        bus.odd_sel   = 1'b0;
        bus.clr_ovr   = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_even_ok();
        test_parity_err();
        test_frame_err();
        test_backpressure();
        test_same_cycle();
        test_gaps();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
